obj_ctrl: RTL and testbench
===========================

OBJ_CTRL -- requirements
Module: obj_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: consecutive cycles the player must stay inside a target box before a pickup or switch press is accepted.
REQ-002 Parameter DARK_PERIOD, default 100_000_000: cycles between light/dark toggles in STAGE2.
REQ-003 clk  in  1  system clock; one clock domain; every flop is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 state  in  4  game state: TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
REQ-006 player_x  in  9  player point, x coordinate, 320x240 space.
REQ-007 player_y  in  9  player point, y coordinate, 320x240 space.
REQ-008 key_find  out  2  number of keys collected in the current stage, 0..3, registered.
REQ-009 isDark  out  1  lights off in STAGE2, registered.
REQ-010 key_pulse  out  1  one-cycle pulse on each accepted key pickup.
REQ-011 all_keys  out  1  high while key_find==3.

Function
REQ-012 Play states are STAGE1, STAGE2 and STAGE3; all other state values are non-play.
REQ-013 Target box for key_find==0 is x 65..84, y 35..54.
REQ-014 Target box for key_find==1 is x 235..254, y 35..54.
REQ-015 Target box for key_find==2 is x 235..254, y 205..224.
REQ-016 key_find==3 has no target box.
REQ-017 Switch box is x 100..119, y 100..119; it is active only in STAGE2 while isDark=1.
REQ-018 Box bounds are inclusive.
REQ-019 Pickup FSM states are IDLE, HOLD and GOT.
REQ-020 IDLE->HOLD when the player is inside the current key box, the state is a play state, and pickup is not blocked.
REQ-021 Pickup is blocked while isDark=1.
REQ-022 In HOLD, a 4-bit counter increments every cycle the player stays inside the box.
REQ-023 HOLD->IDLE with the counter cleared on any cycle the player is outside the box or pickup is blocked.
REQ-024 HOLD->GOT when the counter reaches HOLD_CYCLES-1 while the player is still inside the box.
REQ-025 In GOT, key_find increments and key_pulse=1 for exactly that cycle; the next state is IDLE.
REQ-026 Latency: key_pulse asserts HOLD_CYCLES+1 cycles after the first in-box cycle.
REQ-027 key_find saturates at 3; no HOLD is entered when key_find==3.
REQ-028 all_keys is a registered copy of the condition key_find==3.
REQ-029 Stage entry is a cycle where state differs from its registered previous value and the new value is a play state.
REQ-030 On stage entry, key_find=0, the FSM goes to IDLE, counters clear, isDark=0 and the dark timer clears.
REQ-031 Stage entry overrides any pickup completing in the same cycle.
REQ-032 In any non-play state, key_find=0, the FSM stays in IDLE and key_pulse=0.
REQ-033 Dark timer is 27 bits and counts only while state==STAGE2.
REQ-034 When the dark timer reaches DARK_PERIOD-1, it wraps to 0 and isDark toggles.
REQ-035 Outside STAGE2, isDark=0 and the dark timer is 0.
REQ-036 Switch press: the player stays inside the switch box for HOLD_CYCLES consecutive cycles while isDark=1, using a separate hold counter.
REQ-037 A switch press sets isDark=0 and clears the dark timer.
REQ-038 When a switch press and a timer wrap occur in the same cycle, the switch press wins: isDark=0 and the timer is 0.
REQ-039 Leaving the key or switch box for one cycle restarts the corresponding hold count from 0.

Reset
REQ-040 While rst=1: key_find=0, isDark=0, key_pulse=0, all_keys=0, FSM=IDLE, all counters 0, previous-state register=TITLE.
REQ-041 Reset takes effect on the next clock edge and overrides every other event, including reset in mid-HOLD or in GOT.
REQ-042 After rst=0, a play state already present counts as stage entry on the first cycle.

Verification
REQ-043 Scenario 1: state=2, player at (70,40) for 5 cycles -> key_pulse once, in the 5th cycle; key_find=1.
REQ-044 Scenario 2: player at (70,40) for 3 cycles, then (0,0) for 1 cycle, then (70,40) for 3 cycles -> no pulse; key_find=0.
REQ-045 Scenario 3: sequential visits to (240,40) and (240,210) with key_find=1 -> key_find=2, then 3; all_keys=1 one cycle later; a further visit to (240,210) -> no pulse.
REQ-046 Scenario 4: DARK_PERIOD=10, state=4 -> isDark toggles every 10 cycles; state changed to 5 -> isDark=0 the next cycle.
REQ-047 Scenario 5: DARK_PERIOD=10, isDark=1, player at (110,110) for 4 cycles, the 4th coinciding with a timer wrap -> isDark=0, timer=0.
REQ-048 Scenario 6: key_find=2, state 2->4 -> key_find=0 the next cycle; rst asserted mid-HOLD -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/obj_ctrl.sv
// Key pickup and light-switch control for the three play stages.
// Tracks collected keys, a hold-to-pick-up FSM, and the STAGE2 dark cycle.
module obj_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int DARK_PERIOD = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  output logic [1:0] key_find,
  output logic       isDark,
  output logic       key_pulse,
  output logic       all_keys,
  output logic [1:0] dbg_fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GOT  = 2'd2
  } pick_state_e;

  localparam logic [3:0]  ST_TITLE  = 4'd0;
  localparam logic [3:0]  ST_STAGE1 = 4'd2;
  localparam logic [3:0]  ST_STAGE2 = 4'd4;
  localparam logic [3:0]  ST_STAGE3 = 4'd6;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [26:0] DARK_LAST = 27'(DARK_PERIOD - 1);

  // Every box is 20x20 with inclusive bounds, anchored at its low corner.
  function automatic logic in_box(input logic [8:0] x, input logic [8:0] y,
                                  input logic [8:0] x0, input logic [8:0] y0);
    return (x >= x0) && (x <= x0 + 9'd19) && (y >= y0) && (y <= y0 + 9'd19);
  endfunction

  pick_state_e pick_q, pick_d;
  logic [3:0]  prev_state_q, prev_state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  sw_cnt_q, sw_cnt_d;
  logic [1:0]  key_find_q, key_find_d;
  logic        key_pulse_q, key_pulse_d;
  logic        all_keys_q, all_keys_d;
  logic        dark_q, dark_d;
  logic [26:0] dark_cnt_q, dark_cnt_d;

  logic play, stage_entry, in_key, in_sw, sw_press;

  always_comb begin
    play        = (state == ST_STAGE1) || (state == ST_STAGE2) || (state == ST_STAGE3);
    stage_entry = play && (state != prev_state_q);
    in_sw       = in_box(player_x, player_y, 9'd100, 9'd100);
    case (key_find_q)
      2'd0:    in_key = in_box(player_x, player_y, 9'd65, 9'd35);
      2'd1:    in_key = in_box(player_x, player_y, 9'd235, 9'd35);
      2'd2:    in_key = in_box(player_x, player_y, 9'd235, 9'd205);
      default: in_key = 1'b0;
    endcase
    sw_press = (state == ST_STAGE2) && !stage_entry && dark_q && in_sw &&
               (sw_cnt_q == HOLD_LAST);
  end

  // Dark cycle: a switch press beats a simultaneous timer wrap.
  always_comb begin
    prev_state_d = state;
    dark_d       = dark_q;
    dark_cnt_d   = dark_cnt_q;
    sw_cnt_d     = 4'd0;
    if ((state != ST_STAGE2) || stage_entry) begin
      dark_d     = 1'b0;
      dark_cnt_d = 27'd0;
    end else begin
      if (dark_q && in_sw && !sw_press) sw_cnt_d = sw_cnt_q + 4'd1;
      if (sw_press) begin
        dark_d     = 1'b0;
        dark_cnt_d = 27'd0;
      end else if (dark_cnt_q == DARK_LAST) begin
        dark_d     = ~dark_q;
        dark_cnt_d = 27'd0;
      end else begin
        dark_cnt_d = dark_cnt_q + 27'd1;
      end
    end
  end

  always_comb begin
    pick_d      = pick_q;
    hold_cnt_d  = hold_cnt_q;
    key_find_d  = key_find_q;
    key_pulse_d = 1'b0;
    all_keys_d  = (key_find_q == 2'd3);
    if (!play || stage_entry) begin
      pick_d     = IDLE;
      hold_cnt_d = 4'd0;
      key_find_d = 2'd0;
    end else begin
      case (pick_q)
        IDLE: begin
          hold_cnt_d = 4'd0;
          if (in_key && !dark_q && (key_find_q != 2'd3)) pick_d = HOLD;
        end
        HOLD: begin
          if (!in_key || dark_q) begin
            pick_d     = IDLE;
            hold_cnt_d = 4'd0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            pick_d      = GOT;
            hold_cnt_d  = 4'd0;
            key_pulse_d = 1'b1;
            if (key_find_q != 2'd3) key_find_d = key_find_q + 2'd1;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
        default: begin
          pick_d     = IDLE;
          hold_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pick_q       <= IDLE;
      prev_state_q <= ST_TITLE;
      hold_cnt_q   <= 4'd0;
      sw_cnt_q     <= 4'd0;
      key_find_q   <= 2'd0;
      key_pulse_q  <= 1'b0;
      all_keys_q   <= 1'b0;
      dark_q       <= 1'b0;
      dark_cnt_q   <= 27'd0;
    end else begin
      pick_q       <= pick_d;
      prev_state_q <= prev_state_d;
      hold_cnt_q   <= hold_cnt_d;
      sw_cnt_q     <= sw_cnt_d;
      key_find_q   <= key_find_d;
      key_pulse_q  <= key_pulse_d;
      all_keys_q   <= all_keys_d;
      dark_q       <= dark_d;
      dark_cnt_q   <= dark_cnt_d;
    end
  end

  assign key_find      = key_find_q;
  assign isDark        = dark_q;
  assign key_pulse     = key_pulse_q;
  assign all_keys      = all_keys_q;
  assign dbg_fsm_state = pick_q;

endmodule

// File: tb/tb_obj_ctrl.sv
// Directed bench for obj_ctrl: key pickups, hold restarts, stage entry,
// dark cycle, switch presses and reset, with hand-computed expectations.
module tb_obj_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [8:0] player_x, player_y;
  logic [1:0] key_find;
  logic       isDark, key_pulse, all_keys;
  logic [1:0] dbg_fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int p, p2, p3;

  always #5 clk = ~clk;

  obj_ctrl #(.HOLD_CYCLES(4), .DARK_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .state(state), .player_x(player_x), .player_y(player_y),
    .key_find(key_find), .isDark(isDark), .key_pulse(key_pulse), .all_keys(all_keys),
    .dbg_fsm_state(dbg_fsm_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int x, input int y);
    player_x = 9'(x);
    player_y = 9'(y);
  endtask

  task automatic run_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step(1);
      if (key_pulse) cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; state = 4'd0; put(0, 0);
    step(2);
    check_eq("rst_key_find", 32'(key_find), 0);
    check_eq("rst_is_dark", 32'(isDark), 0);
    check_eq("rst_key_pulse", 32'(key_pulse), 0);
    check_eq("rst_all_keys", 32'(all_keys), 0);
    check_eq("rst_fsm", 32'(dbg_fsm_state), 0);

    rst = 1'b0; state = 4'd2;
    step(1);
    check_eq("s1_entry_key_find", 32'(key_find), 0);

    // Interrupted hold never completes
    put(70, 40); run_pulses(3, p);
    put(0, 0);   run_pulses(1, p2);
    put(70, 40); run_pulses(3, p3);
    check_eq("s2_pulses", 32'(p + p2 + p3), 0);
    check_eq("s2_key_find", 32'(key_find), 0);
    check_eq("s2_in_hold", 32'(dbg_fsm_state), 1);
    put(0, 0); step(1);
    check_eq("s2_back_idle", 32'(dbg_fsm_state), 0);

    put(70, 40);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check_eq($sformatf("s1_pulse_c%0d", i), 32'(key_pulse), 32'(i == 5));
      check_eq($sformatf("s1_key_find_c%0d", i), 32'(key_find), (i == 5) ? 1 : 0);
    end
    step(1);
    check_eq("s1_pulse_one_cycle", 32'(key_pulse), 0);
    check_eq("s1_key_find_held", 32'(key_find), 1);
    check_eq("s1_got_to_idle", 32'(dbg_fsm_state), 0);

    put(0, 0); step(1);
    put(240, 40); run_pulses(5, p);
    check_eq("s3_key2_pulse", 32'(p), 1);
    check_eq("s3_key2_find", 32'(key_find), 2);
    put(0, 0); step(2);
    put(240, 210); run_pulses(5, p);
    check_eq("s3_key3_pulse", 32'(p), 1);
    check_eq("s3_key3_find", 32'(key_find), 3);
    check_eq("s3_all_keys_lag", 32'(all_keys), 0);
    step(1);
    check_eq("s3_all_keys", 32'(all_keys), 1);
    put(0, 0); step(2);
    put(240, 210); run_pulses(6, p);
    check_eq("s3_saturated_pulse", 32'(p), 0);
    check_eq("s3_saturated_find", 32'(key_find), 3);
    check_eq("s3_saturated_idle", 32'(dbg_fsm_state), 0);

    put(0, 0); state = 4'd0; step(1);
    check_eq("nonplay_key_find", 32'(key_find), 0);
    step(1);
    check_eq("nonplay_all_keys", 32'(all_keys), 0);

    state = 4'd2; step(1);
    put(70, 40);  run_pulses(5, p); put(0, 0); step(2);
    put(240, 40); run_pulses(5, p); put(0, 0); step(2);
    check_eq("s6_two_keys", 32'(key_find), 2);
    state = 4'd4; step(1);
    check_eq("s6_entry_key_find", 32'(key_find), 0);
    check_eq("s4_entry_dark", 32'(isDark), 0);

    step(9);  check_eq("s4_dark_e9", 32'(isDark), 0);
    step(1);  check_eq("s4_dark_e10", 32'(isDark), 1);
    step(9);  check_eq("s4_dark_e19", 32'(isDark), 1);
    step(1);  check_eq("s4_dark_e20", 32'(isDark), 0);
    step(10); check_eq("s4_dark_e30", 32'(isDark), 1);
    state = 4'd5; step(1);
    check_eq("s4_leave_stage2", 32'(isDark), 0);

    state = 4'd4; step(1);
    check_eq("s5_entry_dark", 32'(isDark), 0);
    step(16); check_eq("s5_dark_f16", 32'(isDark), 1);
    put(110, 110); step(4);
    check_eq("s5_press_on_wrap", 32'(isDark), 0);
    put(0, 0); step(10);
    check_eq("s5_dark_f30", 32'(isDark), 1);
    step(2); put(110, 110); step(4);
    check_eq("sw_press_dark", 32'(isDark), 0);
    put(0, 0); step(4);
    check_eq("sw_timer_cleared", 32'(isDark), 0);
    step(6);
    check_eq("sw_dark_again", 32'(isDark), 1);
    put(70, 40); run_pulses(5, p);
    check_eq("dark_blocks_pulse", 32'(p), 0);
    check_eq("dark_blocks_find", 32'(key_find), 0);
    check_eq("dark_blocks_fsm", 32'(dbg_fsm_state), 0);

    state = 4'd2; step(1);
    run_pulses(5, p);
    check_eq("s6_pickup_pulse", 32'(p), 1);
    put(240, 40); step(3);
    check_eq("s6_mid_hold", 32'(dbg_fsm_state), 1);
    check_eq("s6_mid_hold_find", 32'(key_find), 1);
    rst = 1'b1; step(1);
    check_eq("s6_rst_key_find", 32'(key_find), 0);
    check_eq("s6_rst_dark", 32'(isDark), 0);
    check_eq("s6_rst_pulse", 32'(key_pulse), 0);
    check_eq("s6_rst_all_keys", 32'(all_keys), 0);
    check_eq("s6_rst_fsm", 32'(dbg_fsm_state), 0);

    // Play state present at reset release is a stage entry
    rst = 1'b0; put(70, 40); step(1);
    check_eq("post_rst_entry_idle", 32'(dbg_fsm_state), 0);
    step(1);
    check_eq("post_rst_hold", 32'(dbg_fsm_state), 1);
    step(3);
    check_eq("pre_override_hold", 32'(dbg_fsm_state), 1);
    state = 4'd6; step(1);
    check_eq("entry_override_pulse", 32'(key_pulse), 0);
    check_eq("entry_override_find", 32'(key_find), 0);
    check_eq("entry_override_fsm", 32'(dbg_fsm_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
